// File: rtl/muldiv_sequencer.sv
// Bit-serial unsigned 16x16 multiply / 16/16 restoring divide driven through an external ALU.
// Build option: define MULDIV_DIV_EN to implement DIVU; otherwise DIVU returns out_err with a zero result.
module muldiv_sequencer #(
  parameter logic [3:0] ALU_ADD = 4'b0010,
  parameter logic [3:0] ALU_SUB = 4'b0110
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_op,
  input  logic [15:0] in_a,
  input  logic [15:0] in_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_hi,
  output logic [15:0] out_lo,
  output logic        out_err,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [3:0]  alu_op,
  input  logic [15:0] alu_result,
  input  logic        alu_carry,
  output logic        busy
);

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_DONE} state_t;

  state_t      r_state;
  logic [15:0] r_acc;    // MUL: acc, DIVU: rem
  logic [15:0] r_mplr;   // MUL: mplr, DIVU: quo
  logic [15:0] r_mcand;  // MUL: mcand, DIVU: divisor
  logic [3:0]  r_cnt;
  logic        r_err;

  logic [15:0] w_mul_acc_next;
  logic [15:0] w_mul_mplr_next;

  assign w_mul_acc_next  = r_mplr[0] ? {alu_carry, alu_result[15:1]} : {1'b0, r_acc[15:1]};
  assign w_mul_mplr_next = {(r_mplr[0] ? alu_result[0] : r_acc[0]), r_mplr[15:1]};

`ifdef MULDIV_DIV_EN
  logic        r_op;
  logic [15:0] w_s;
  logic        w_take;
  logic [15:0] w_rem_next;
  logic [15:0] w_quo_next;

  // rem[15] means the shifted value is 17 bits wide and therefore exceeds any divisor
  assign w_s        = {r_acc[14:0], r_mplr[15]};
  assign w_take     = r_acc[15] | alu_carry;
  assign w_rem_next = w_take ? alu_result : w_s;
  assign w_quo_next = {r_mplr[14:0], w_take};
`endif

  always_comb begin
    alu_a  = 16'h0000;
    alu_b  = 16'h0000;
    alu_op = ALU_ADD;
    if (r_state == S_ITER) begin
      alu_b = r_mcand;
`ifdef MULDIV_DIV_EN
      if (r_op) begin
        alu_a  = w_s;
        alu_op = ALU_SUB;
      end else begin
        alu_a = r_acc;
      end
`else
      alu_a = r_acc;
`endif
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign out_hi    = r_acc;
  assign out_lo    = r_mplr;
  assign out_err   = r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_acc   <= 16'h0000;
      r_mplr  <= 16'h0000;
      r_mcand <= 16'h0000;
      r_cnt   <= 4'd0;
      r_err   <= 1'b0;
`ifdef MULDIV_DIV_EN
      r_op    <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_cnt <= 4'd0;
            r_err <= 1'b0;
            r_acc <= 16'h0000;
`ifdef MULDIV_DIV_EN
            r_op  <= in_op;
`endif
            if (in_op) begin
`ifdef MULDIV_DIV_EN
              r_mcand <= in_b;
              if (in_b == 16'h0000) begin
                r_acc   <= in_a;
                r_mplr  <= 16'hFFFF;
                r_err   <= 1'b1;
                r_state <= S_DONE;
              end else begin
                r_mplr  <= in_a;
                r_state <= S_ITER;
              end
`else
              r_mplr  <= 16'h0000;
              r_err   <= 1'b1;
              r_state <= S_DONE;
`endif
            end else begin
              r_mplr  <= in_b;
              r_mcand <= in_a;
              r_state <= S_ITER;
            end
          end
        end
        S_ITER: begin
          r_cnt <= r_cnt + 4'd1;
`ifdef MULDIV_DIV_EN
          if (r_op) begin
            r_acc  <= w_rem_next;
            r_mplr <= w_quo_next;
          end else begin
            r_acc  <= w_mul_acc_next;
            r_mplr <= w_mul_mplr_next;
          end
`else
          r_acc  <= w_mul_acc_next;
          r_mplr <= w_mul_mplr_next;
`endif
          if (r_cnt == 4'd15) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Multi-cycle controller that runs unsigned 16×16 multiply and 16/16 divide on the shared 16-bit ALU, one bit per cycle. It drives the ALU operand and opcode inputs and consumes its result and carry. It sits beside the register file and accepts one command at a time over a valid/ready handshake. Results are returned over a second valid/ready handshake.

## Interface
Parameters:
- ALU_ADD, 4'b0010, ALU opcode for A+B
- ALU_SUB, 4'b0110, ALU opcode for A−B; ALU carry = 1 means no borrow (A ≥ B)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  command valid
- in_ready  out  1  command accepted when high with in_valid
- in_op  in  1  0 = MUL, 1 = DIVU
- in_a  in  16  multiplicand / dividend
- in_b  in  16  multiplier / divisor
- out_valid  out  1  result valid
- out_ready  in  1  result consumed when high with out_valid
- out_hi  out  16  MUL: product[31:16]; DIVU: remainder
- out_lo  out  16  MUL: product[15:0]; DIVU: quotient
- out_err  out  1  divide-by-zero or disabled op
- alu_a, alu_b  out  16  ALU operands
- alu_op  out  4  ALU opcode
- alu_result  in  16  ALU result (combinational)
- alu_carry  in  1  ALU carry-out
- busy  out  1  state ≠ IDLE

## Operation
- FSM states: IDLE, ITER, DONE. in_ready = (state == IDLE).
- Accept (in_valid & in_ready):
  - Latch op and operands.
  - Clear acc/rem and the 4-bit counter.
  - Go to ITER.
- DIVU with in_b = 0: skip ITER and go straight to DONE with out_err = 1, out_hi = in_a, out_lo = 16'hFFFF.
- MUL iteration (registers acc, mplr; mcand fixed):
  - alu_a = acc, alu_b = mcand, alu_op = ALU_ADD.
  - If mplr[0] = 1: acc ← {alu_carry, alu_result[15:1]}, mplr ← {alu_result[0], mplr[15:1]}.
  - Else: acc ← {0, acc[15:1]}, mplr ← {acc[0], mplr[15:1]}.
  - Final: out_hi = acc, out_lo = mplr.
- DIVU iteration (registers rem, quo; divisor fixed), restoring:
  - s = {rem[14:0], quo[15]}; alu_a = s, alu_b = divisor, alu_op = ALU_SUB.
  - take = rem[15] | alu_carry (rem[15] covers the 17-bit shifted value).
  - rem ← take ? alu_result : s; quo ← {quo[14:0], take}.
  - Final: out_hi = rem, out_lo = quo.
- Counter increments each ITER cycle. At the edge where the counter = 15, go to DONE. The counter wraps to 0 and is unused afterwards.
- IDLE and DONE drive alu_a = alu_b = 0, alu_op = ALU_ADD.
- DONE: out_valid = 1, outputs held stable. On out_ready, go to IDLE and drop out_valid. No new command is accepted in the same cycle.

## Timing
- Reset (async assert, sync-safe release):
  - state = IDLE; all datapath registers = 0.
  - Outputs: out_valid = 0, out_err = 0, out_hi = out_lo = 0, busy = 0, in_ready = 1.
- Latency: out_valid rises 16 cycles after the accept edge. Divide-by-zero and disabled ops: 1 cycle.
- Throughput: one command per 17 cycles plus the out_ready wait, plus one IDLE cycle.
- Backpressure: while out_ready is low in DONE, out_* are stable and in_ready = 0.
- Reset mid-ITER or mid-DONE aborts the operation. No result is emitted and in_ready = 1 after deassertion.
- in_* is ignored outside IDLE.

## Configuration
- MULDIV_DIV_EN defined: DIVU is implemented as above.
- MULDIV_DIV_EN undefined:
  - The divide datapath and the take logic are removed.
  - in_op = 1 is still accepted and goes to DONE the next cycle with out_err = 1, out_hi = out_lo = 0.
  - MUL is unchanged.

## Test plan
- MUL 0xFFFF × 0xFFFF → out_hi = 0xFFFE, out_lo = 0x0001, out_err = 0; out_valid exactly 16 cycles after accept.
- DIVU 0xFFFF / 0x8001 → out_lo = 0x0001, out_hi = 0x7FFE (exercises the rem[15] path); DIVU 100 / 7 → q = 14, r = 2.
- DIVU 0x1234 / 0 → out_err = 1, out_hi = 0x1234, out_lo = 0xFFFF, 1 cycle after accept.
- MUL 3 × 5 with out_ready low for 5 cycles in DONE → out_hi/out_lo = 0x0000/0x000F stable, in_ready = 0 throughout; in_ready = 1 the cycle after release.
- rst_n pulsed low during the 7th ITER cycle of any op → out_valid never asserts, busy = 0 immediately; the next MUL 2 × 2 returns 0x0000/0x0004.
- MULDIV_DIV_EN undefined, DIVU 10 / 2 → out_err = 1, result 0, 1-cycle latency.
